// File: rtl/bcd_scan_driver_if.sv
// Upstream value handshake for bcd_scan_driver.
// valid/ready: the producer raises in_valid with in_data and holds both
// steady until a rising clk edge sees in_valid && in_ready; that edge is the
// transfer. in_ready never waits on in_valid.
interface bcd_scan_driver_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  // Producer side
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Consumer side (the scan driver)
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: takes an 8-bit binary value, converts it to 3 BCD digits
// by sequential double-dabble, and time-multiplexes the digits onto bin with
// one-hot digit enables for a multiplexed 7-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits
// by driving bin = 4'hF; the units digit is never blanked).
module bcd_scan_driver #(
  parameter int NUM_DIGITS  = 3,    // 3..4, digit 3 always shows 0
  parameter int REFRESH_DIV = 1000  // dwell per digit in clk cycles, >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_scan_driver_if.slave      up,
  output logic [3:0]            bin,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  busy,
  output logic                  state_dbg   // 0 = IDLE, 1 = CONV
);

  localparam int IW = 2;
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t state, state_next;

  // Converter datapath
  logic [7:0]  shift;
  logic [11:0] bcd;
  logic [2:0]  cnt;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_sh;
  logic [7:0]  shift_sh;
  logic        accept;
  logic        last_step;

  // Display registers: hundreds, tens, units
  logic [3:0] d2, d1, d0;

  // Scanner
  logic [PW-1:0]         presc, presc_next;
  logic [IW-1:0]         idx, idx_next;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] dig_en_next;
  logic [3:0]            bin_next;
  logic [3:0]            tens_shown, hund_shown, fourth_shown;

  assign accept    = up.in_valid && up.in_ready;
  assign last_step = (state == S_CONV) && (cnt == 3'd7);

  // Converter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Converter next-state: one accept starts eight shift steps
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept)    state_next = S_CONV;
      S_CONV: if (last_step) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // Converter outputs decoded from state
  always_comb begin
    up.in_ready = (state == S_IDLE);
    busy        = (state == S_CONV);
    state_dbg   = state;
  end

  // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,shift} left
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 3; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
    bcd_sh   = {bcd_adj[10:0], shift[7]};
    shift_sh = {shift[6:0], 1'b0};
  end

  // Converter datapath and display registers; display changes only on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      bcd   <= '0;
      cnt   <= '0;
      d2    <= '0;
      d1    <= '0;
      d0    <= '0;
    end else if (accept) begin
      shift <= up.in_data;
      bcd   <= '0;
      cnt   <= '0;
    end else if (state == S_CONV) begin
      shift <= shift_sh;
      bcd   <= bcd_sh;
      cnt   <= cnt + 3'd1;
      if (last_step) begin
        d2 <= bcd_sh[11:8];
        d1 <= bcd_sh[7:4];
        d0 <= bcd_sh[3:0];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading zeros above the highest non-zero digit go blank; units always shows
  always_comb begin
    hund_shown   = (d2 == 4'd0) ? 4'hF : d2;
    tens_shown   = ((d2 == 4'd0) && (d1 == 4'd0)) ? 4'hF : d1;
    fourth_shown = 4'hF;
  end
`else
  // Every digit shows its value, zero padding included
  always_comb begin
    hund_shown   = d2;
    tens_shown   = d1;
    fourth_shown = 4'h0;
  end
`endif

  // Scanner next values: prescaler wrap advances the digit index
  always_comb begin
    wrap       = (presc == PW'(REFRESH_DIV - 1));
    presc_next = wrap ? '0 : presc + PW'(1);
    idx_next   = idx;
    if (wrap) idx_next = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    dig_en_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) dig_en_next[i] = (idx_next == IW'(i));
    case (idx_next)
      2'd0:    bin_next = d0;
      2'd1:    bin_next = tens_shown;
      2'd2:    bin_next = hund_shown;
      default: bin_next = fourth_shown;
    endcase
  end

  // Scanner registers: bin and dig_en always move on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      idx    <= '0;
      dig_en <= NUM_DIGITS'(1);
      bin    <= 4'd0;
    end else begin
      presc  <= presc_next;
      idx    <= idx_next;
      dig_en <= dig_en_next;
      bin    <= bin_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver with NUM_DIGITS=3, REFRESH_DIV=4.
// Honours LEADING_ZERO_BLANK_EN when defined for expected blank digits.
module tb_bcd_scan_driver;
  localparam int ND = 3;
  localparam int RD = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ = 4'hF;
`else
  localparam logic [3:0] LZ = 4'h0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_scan_driver_if up_if ();
  logic [3:0]    bin;
  logic [ND-1:0] dig_en;
  logic          busy;
  logic          state_dbg;

  bcd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up_if.slave),
    .bin       (bin),
    .dig_en    (dig_en),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v and return #1 after the accepting edge; in_valid dropped.
  task automatic send(input logic [7:0] v);
    int n = 0;
    up_if.in_valid = 1'b1;
    up_if.in_data  = v;
    while (!up_if.in_ready && n < 40) begin tick(); n++; end
    tick();
    up_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!up_if.in_ready && n < 40) begin tick(); n++; end
  endtask

  // Wait for a fresh entry into digit enable en and return bin there.
  task automatic wait_fresh(input logic [ND-1:0] en, output logic [3:0] b, output bit ok);
    int n = 0;
    while (dig_en === en && n < 40) begin tick(); n++; end
    while (dig_en !== en && n < 40) begin tick(); n++; end
    ok = (dig_en === en);
    b  = bin;
  endtask

  task automatic read_scan(output logic [3:0] u, output logic [3:0] t, output logic [3:0] h,
                           output bit ok);
    bit o1, o2, o3;
    wait_fresh(3'b001, u, o1);
    wait_fresh(3'b010, t, o2);
    wait_fresh(3'b100, h, o3);
    ok = o1 && o2 && o3;
  endtask

  // scenarios
  task automatic test_reset();
    logic [3:0] u, t, h, e;
    bit ok;
    rst_n = 1'b0;
    up_if.in_valid = 1'b0;
    up_if.in_data  = 8'd0;
    repeat (3) tick();
    n_cmp++; if (up_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", up_if.in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (dig_en !== 3'b001) begin n_bad++; $display("FAIL reset_dig_en got=%b want=001", dig_en); end
    n_cmp++; if (bin !== 4'd0) begin n_bad++; $display("FAIL reset_bin got=%h want=0", bin); end
    rst_n = 1'b1;
    exp_q.push_back(4'd0); exp_q.push_back(LZ); exp_q.push_back(LZ);
    read_scan(u, t, h, ok);
    e = exp_q.pop_front(); n_cmp++; if (!ok || u !== e) begin n_bad++; $display("FAIL reset_scan_units got=%h want=%h ok=%0d", u, e, ok); end
    e = exp_q.pop_front(); n_cmp++; if (!ok || t !== e) begin n_bad++; $display("FAIL reset_scan_tens got=%h want=%h ok=%0d", t, e, ok); end
    e = exp_q.pop_front(); n_cmp++; if (!ok || h !== e) begin n_bad++; $display("FAIL reset_scan_hund got=%h want=%h ok=%0d", h, e, ok); end
  endtask

  task automatic test_convert_255();
    logic [3:0] u, t, h, e;
    bit ok;
    int n;
    send(8'd255);
    n_cmp++; if (busy !== 1'b1 || up_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL conv255_start busy=%b ready=%b want busy=1 ready=0", busy, up_if.in_ready); end
    wait_idle(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL conv255_latency got=%0d want=8", n); end
    tick();
    e = (dig_en == 3'b100) ? 4'd2 : 4'd5;
    n_cmp++; if (bin !== e) begin n_bad++; $display("FAIL conv255_next_edge_bin got=%h want=%h en=%b", bin, e, dig_en); end
    exp_q.push_back(4'd5); exp_q.push_back(4'd5); exp_q.push_back(4'd2);
    read_scan(u, t, h, ok);
    e = exp_q.pop_front(); n_cmp++; if (!ok || u !== e) begin n_bad++; $display("FAIL conv255_units got=%h want=%h", u, e); end
    e = exp_q.pop_front(); n_cmp++; if (!ok || t !== e) begin n_bad++; $display("FAIL conv255_tens got=%h want=%h", t, e); end
    e = exp_q.pop_front(); n_cmp++; if (!ok || h !== e) begin n_bad++; $display("FAIL conv255_hund got=%h want=%h", h, e); end
  endtask

  task automatic test_scan_123();
    logic [3:0] b;
    logic [ND-1:0] en_seq [3];
    logic [3:0]    bin_seq[3];
    logic [ND-1:0] prev;
    bit ok;
    int n;
    en_seq[0] = 3'b010; en_seq[1] = 3'b100; en_seq[2] = 3'b001;
    bin_seq[0] = 4'd2;  bin_seq[1] = 4'd1;  bin_seq[2] = 4'd3;
    send(8'd123);
    wait_idle(n);
    wait_fresh(3'b001, b, ok);
    n_cmp++; if (!ok || b !== 4'd3) begin n_bad++; $display("FAIL scan123_first got=%h want=3 ok=%0d", b, ok); end
    for (int k = 0; k < 3; k++) begin
      prev = dig_en;
      n = 0;
      while (dig_en === prev && n < 20) begin tick(); n++; end
      n_cmp++; if (n !== RD) begin n_bad++; $display("FAIL scan123_dwell%0d got=%0d want=%0d", k, n, RD); end
      n_cmp++; if (dig_en !== en_seq[k]) begin n_bad++; $display("FAIL scan123_en%0d got=%b want=%b", k, dig_en, en_seq[k]); end
      n_cmp++; if (bin !== bin_seq[k]) begin n_bad++; $display("FAIL scan123_bin%0d got=%h want=%h", k, bin, bin_seq[k]); end
    end
  endtask

  task automatic test_hold_during_conv();
    logic [3:0] u, t, h, e;
    bit ok;
    int n;
    up_if.in_valid = 1'b1;
    up_if.in_data  = 8'd9;
    n = 0;
    while (!up_if.in_ready && n < 40) begin tick(); n++; end
    tick();
    up_if.in_data = 8'd200;
    n_cmp++; if (up_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready_low got=%b want=0", up_if.in_ready); end
    wait_idle(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL hold_first_latency got=%0d want=8", n); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_second_accept busy=%b want=1", busy); end
    e = (dig_en == 3'b001) ? 4'd9 : LZ;
    n_cmp++; if (bin !== e) begin n_bad++; $display("FAIL hold_nine_shown got=%h want=%h en=%b", bin, e, dig_en); end
    up_if.in_valid = 1'b0;
    wait_idle(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL hold_second_latency got=%0d want=8", n); end
    exp_q.push_back(4'd0); exp_q.push_back(4'd0); exp_q.push_back(4'd2);
    read_scan(u, t, h, ok);
    e = exp_q.pop_front(); n_cmp++; if (!ok || u !== e) begin n_bad++; $display("FAIL hold200_units got=%h want=%h", u, e); end
    e = exp_q.pop_front(); n_cmp++; if (!ok || t !== e) begin n_bad++; $display("FAIL hold200_tens got=%h want=%h", t, e); end
    e = exp_q.pop_front(); n_cmp++; if (!ok || h !== e) begin n_bad++; $display("FAIL hold200_hund got=%h want=%h", h, e); end
  endtask

  task automatic test_reset_mid_conv();
    logic [3:0] u, t, h, e;
    bit ok;
    int nines = 0;
    send(8'd99);
    repeat (4) tick();
    n_cmp++; if (state_dbg !== 1'b1) begin n_bad++; $display("FAIL midrst_in_conv state=%b want=1", state_dbg); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (up_if.in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_ctrl ready=%b busy=%b want 1/0", up_if.in_ready, busy); end
    n_cmp++; if (dig_en !== 3'b001 || bin !== 4'd0) begin n_bad++; $display("FAIL midrst_disp en=%b bin=%h want 001/0", dig_en, bin); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bin === 4'd9) nines++;
    end
    n_cmp++; if (nines !== 0) begin n_bad++; $display("FAIL midrst_no_99 got=%0d nine-cycles want=0", nines); end
    exp_q.push_back(4'd0); exp_q.push_back(LZ); exp_q.push_back(LZ);
    read_scan(u, t, h, ok);
    e = exp_q.pop_front(); n_cmp++; if (!ok || u !== e) begin n_bad++; $display("FAIL midrst_units got=%h want=%h", u, e); end
    e = exp_q.pop_front(); n_cmp++; if (!ok || t !== e) begin n_bad++; $display("FAIL midrst_tens got=%h want=%h", t, e); end
    e = exp_q.pop_front(); n_cmp++; if (!ok || h !== e) begin n_bad++; $display("FAIL midrst_hund got=%h want=%h", h, e); end
  endtask

  task automatic test_small_values();
    logic [3:0] u, t, h, e;
    logic [7:0] vals[2];
    logic [3:0] units[2];
    bit ok;
    int n;
    vals[0] = 8'd7; units[0] = 4'd7;
    vals[1] = 8'd0; units[1] = 4'd0;
    for (int k = 0; k < 2; k++) begin
      send(vals[k]);
      wait_idle(n);
      exp_q.push_back(units[k]); exp_q.push_back(LZ); exp_q.push_back(LZ);
      read_scan(u, t, h, ok);
      e = exp_q.pop_front(); n_cmp++; if (!ok || u !== e) begin n_bad++; $display("FAIL small%0d_units got=%h want=%h", vals[k], u, e); end
      e = exp_q.pop_front(); n_cmp++; if (!ok || t !== e) begin n_bad++; $display("FAIL small%0d_tens got=%h want=%h", vals[k], t, e); end
      e = exp_q.pop_front(); n_cmp++; if (!ok || h !== e) begin n_bad++; $display("FAIL small%0d_hund got=%h want=%h", vals[k], h, e); end
    end
  endtask

  // sequence and final report
  initial begin
    up_if.in_valid = 1'b0;
    up_if.in_data  = 8'd0;
    test_reset();
    test_convert_255();
    test_scan_123();
    test_hold_during_conv();
    test_reset_mid_conv();
    test_small_values();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
